// File: rtl/sdes_round_engine_if.sv
// Handshake bundle for the S-DES round engine: key load, block in, result out.
interface sdes_round_engine_if;
   logic [9:0] key_in;
   logic       key_load;
   logic       key_ready;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] q_in;
   logic       decrypt;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] cipher;
   logic [3:0] debug;

   // Block source / key source side
   modport master (
      output key_in, key_load, in_valid, q_in, decrypt, out_ready,
      input  key_ready, in_ready, out_valid, cipher, debug
   );

   // Engine side
   modport slave (
      input  key_in, key_load, in_valid, q_in, decrypt, out_ready,
      output key_ready, in_ready, out_valid, cipher, debug
   );
endinterface

// File: rtl/sdes_round_engine.sv
// Iterative S-DES engine: expands the 10-bit key into ROUNDS subkeys (one per
// cycle), then runs one Feistel round per cycle on an accepted block.
// ROUNDS=2 reproduces standard S-DES exactly.
module sdes_round_engine #(
   parameter int ROUNDS = 2
) (
   input logic               clk,
   input logic               reset,
   sdes_round_engine_if.slave bus
);

   localparam int         IDXW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [3:0] LAST = 4'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      KEYGEN = 2'b01,
      RUN    = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [9:0]        keyHalves_q, keyHalves_d;
   logic              keyReady_q, keyReady_d;
   logic [7:0]        data_q, data_d;
   logic              dec_q, dec_d;
   logic [7:0]        cipher_q, cipher_d;
   logic [7:0]        subkeys_q [ROUNDS];

   logic              inReady;
   logic              skWe;
   logic [IDXW-1:0]   skIdx;
   logic [7:0]        skData;
   logic [IDXW-1:0]   rkIdx;
   logic [7:0]        roundKey;
   logic [3:0]        newLeft;

   // S-DES numbering: bit 1 is the MSB, so bit i of an N-bit word is x[N-i]
   function automatic logic [9:0] p10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   function automatic logic [7:0] p8(input logic [9:0] k);
      return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
   endfunction

   function automatic logic [7:0] ip(input logic [7:0] x);
      return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
   endfunction

   function automatic logic [7:0] ipInv(input logic [7:0] x);
      return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
   endfunction

   function automatic logic [4:0] rotl1(input logic [4:0] x);
      return {x[3:0], x[4]};
   endfunction

   function automatic logic [4:0] rotl2(input logic [4:0] x);
      return {x[2:0], x[4:3]};
   endfunction

   // Row is {bit1,bit4}, column is {bit2,bit3}
   function automatic logic [1:0] sbox0(input logic [3:0] v);
      logic [1:0] r;
      case ({v[3], v[0], v[2], v[1]})
         4'd0:  r = 2'd1;  4'd1:  r = 2'd0;  4'd2:  r = 2'd3;  4'd3:  r = 2'd2;
         4'd4:  r = 2'd3;  4'd5:  r = 2'd2;  4'd6:  r = 2'd1;  4'd7:  r = 2'd0;
         4'd8:  r = 2'd0;  4'd9:  r = 2'd2;  4'd10: r = 2'd1;  4'd11: r = 2'd3;
         4'd12: r = 2'd3;  4'd13: r = 2'd1;  4'd14: r = 2'd3;  default: r = 2'd2;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] sbox1(input logic [3:0] v);
      logic [1:0] r;
      case ({v[3], v[0], v[2], v[1]})
         4'd0:  r = 2'd0;  4'd1:  r = 2'd1;  4'd2:  r = 2'd2;  4'd3:  r = 2'd3;
         4'd4:  r = 2'd2;  4'd5:  r = 2'd0;  4'd6:  r = 2'd1;  4'd7:  r = 2'd3;
         4'd8:  r = 2'd3;  4'd9:  r = 2'd0;  4'd10: r = 2'd1;  4'd11: r = 2'd0;
         4'd12: r = 2'd2;  4'd13: r = 2'd1;  4'd14: r = 2'd0;  default: r = 2'd3;
      endcase
      return r;
   endfunction

   // F(R,K) = P4(S0 || S1 (E/P(R) xor K))
   function automatic logic [3:0] feistel(input logic [3:0] r, input logic [7:0] k);
      logic [7:0] v;
      logic [3:0] s;
      v = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
      s = {sbox0(v[7:4]), sbox1(v[3:0])};
      return {s[2], s[0], s[1], s[3]};
   endfunction

   // Halves are held pre-rotated so each keygen cycle only needs a further rotate by 2
   function automatic logic [9:0] loadHalves(input logic [9:0] k);
      logic [9:0] p;
      p = p10(k);
      return {rotl1(p[9:5]), rotl1(p[4:0])};
   endfunction

   // Subkey written in keygen and the key selected for the current round
   always_comb begin
      skIdx    = IDXW'(cnt_q);
      skData   = p8(keyHalves_q);
      rkIdx    = dec_q ? IDXW'(LAST - cnt_q) : IDXW'(cnt_q);
      roundKey = subkeys_q[rkIdx];
      newLeft  = data_q[7:4] ^ feistel(data_q[3:0], roundKey);
   end

   // Next-state and handshake logic for key expansion and block processing
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      keyHalves_d = keyHalves_q;
      keyReady_d  = keyReady_q;
      data_d      = data_q;
      dec_d       = dec_q;
      cipher_d    = cipher_q;
      skWe        = 1'b0;
      inReady     = 1'b0;
      case (state_q)
         IDLE: begin
            inReady = keyReady_q && !bus.key_load;
            if (bus.key_load) begin
               state_d     = KEYGEN;
               keyReady_d  = 1'b0;
               cnt_d       = '0;
               keyHalves_d = loadHalves(bus.key_in);
            end else if (bus.in_valid && inReady) begin
               state_d = RUN;
               data_d  = ip(bus.q_in);
               dec_d   = bus.decrypt;
               cnt_d   = '0;
            end
         end
         KEYGEN: begin
            if (bus.key_load) begin
               cnt_d       = '0;
               keyHalves_d = loadHalves(bus.key_in);
            end else begin
               skWe        = 1'b1;
               keyHalves_d = {rotl2(keyHalves_q[9:5]), rotl2(keyHalves_q[4:0])};
               if (cnt_q == LAST) begin
                  state_d    = IDLE;
                  keyReady_d = 1'b1;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         RUN: begin
            if (cnt_q == LAST) begin
               cipher_d = ipInv({newLeft, data_q[3:0]});
               state_d  = DONE;
            end else begin
               data_d = {data_q[3:0], newLeft};
               cnt_d  = cnt_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         keyHalves_q <= '0;
         keyReady_q  <= 1'b0;
         data_q      <= '0;
         dec_q       <= 1'b0;
         cipher_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         keyHalves_q <= keyHalves_d;
         keyReady_q  <= keyReady_d;
         data_q      <= data_d;
         dec_q       <= dec_d;
         cipher_q    <= cipher_d;
      end
   end

   // Subkey file, filled one entry per keygen cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ROUNDS; i++) subkeys_q[i] <= '0;
      end else if (skWe) begin
         subkeys_q[skIdx] <= skData;
      end
   end

   assign bus.key_ready = keyReady_q;
   assign bus.in_ready  = inReady;
   assign bus.out_valid = (state_q == DONE);
   assign bus.cipher    = cipher_q;
   assign bus.debug     = {state_q, cnt_q[1:0]};

endmodule

// File: tb/tb_sdes_round_engine.sv
// Self-checking bench: a ROUNDS=2 engine against known S-DES vectors and a
// ROUNDS=4 engine for encrypt/decrypt round trips, both through a scoreboard.
module tb_sdes_round_engine;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [9:0] keyIn     [2];
   logic       keyLoad   [2];
   logic       inValid   [2];
   logic [7:0] qIn       [2];
   logic       decIn     [2];
   logic       outReady  [2];
   logic       keyReady  [2];
   logic       inReady   [2];
   logic       outValid  [2];
   logic [7:0] cipherOut [2];
   logic [3:0] debugOut  [2];

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] sb0 [$];
   logic [7:0] sb1 [$];

   localparam int RND [2] = '{2, 4};

   localparam int P10T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
   localparam int IPT  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
   localparam int IPIT [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
   localparam int EPT  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
   localparam int P4T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
   localparam int S0T  [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   localparam int S1T  [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   sdes_round_engine_if ifA ();
   sdes_round_engine_if ifB ();

   sdes_round_engine #(.ROUNDS(2)) dutA (.clk(clock), .reset(reset), .bus(ifA.slave));
   sdes_round_engine #(.ROUNDS(4)) dutB (.clk(clock), .reset(reset), .bus(ifB.slave));

   assign ifA.key_in    = keyIn[0];
   assign ifA.key_load  = keyLoad[0];
   assign ifA.in_valid  = inValid[0];
   assign ifA.q_in      = qIn[0];
   assign ifA.decrypt   = decIn[0];
   assign ifA.out_ready = outReady[0];
   assign keyReady[0]   = ifA.key_ready;
   assign inReady[0]    = ifA.in_ready;
   assign outValid[0]   = ifA.out_valid;
   assign cipherOut[0]  = ifA.cipher;
   assign debugOut[0]   = ifA.debug;

   assign ifB.key_in    = keyIn[1];
   assign ifB.key_load  = keyLoad[1];
   assign ifB.in_valid  = inValid[1];
   assign ifB.q_in      = qIn[1];
   assign ifB.decrypt   = decIn[1];
   assign ifB.out_ready = outReady[1];
   assign keyReady[1]   = ifB.key_ready;
   assign inReady[1]    = ifB.in_ready;
   assign outValid[1]   = ifB.out_valid;
   assign cipherOut[1]  = ifB.cipher;
   assign debugOut[1]   = ifB.debug;

   // Free-running clock
   always #5 clock = ~clock;

   // Hard stop in case a handshake never completes
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Generic S-DES permutation: output bit j takes source bit tbl[j] (bit 1 = MSB)
   function automatic logic [9:0] permute(input logic [9:0] src, input int srcW, input int tbl [10], input int n);
      logic [9:0] r;
      r = '0;
      for (int j = 0; j < n; j++) r[n-1-j] = src[srcW - tbl[j]];
      return r;
   endfunction

   function automatic logic [7:0] modelCrypt(input int rounds, input logic [9:0] key, input logic [7:0] x, input logic dec);
      logic [9:0] p, t;
      logic [4:0] lh, rh;
      logic [7:0] sk [16];
      logic [3:0] l, r, tmp, f;
      logic [7:0] v;
      int         sh, s0, s1;
      p = permute(key, 10, P10T, 10);
      for (int k = 1; k <= rounds; k++) begin
         lh = p[9:5];
         rh = p[4:0];
         sh = (1 + 2 * (k - 1)) % 5;
         for (int s = 0; s < sh; s++) begin
            lh = {lh[3:0], lh[4]};
            rh = {rh[3:0], rh[4]};
         end
         t = permute({lh, rh}, 10, P8T, 8);
         sk[k-1] = t[7:0];
      end
      t = permute({2'b00, x}, 8, IPT, 8);
      l = t[7:4];
      r = t[3:0];
      for (int i = 0; i < rounds; i++) begin
         t  = permute({6'b0, r}, 4, EPT, 8);
         v  = t[7:0] ^ (dec ? sk[rounds-1-i] : sk[i]);
         s0 = S0T[{v[7], v[4]} * 4 + {v[6], v[5]}];
         s1 = S1T[{v[3], v[0]} * 4 + {v[2], v[1]}];
         t  = permute({6'b0, s0[1:0], s1[1:0]}, 4, P4T, 4);
         f  = t[3:0];
         l  = l ^ f;
         if (i != rounds - 1) begin
            tmp = l;
            l   = r;
            r   = tmp;
         end
      end
      t = permute({2'b00, l, r}, 8, IPIT, 8);
      return t[7:0];
   endfunction

   task automatic stepCycle();
      @(posedge clock);
      #2;
   endtask

   // Scoreboard consumer: compares every result that the sink takes
   always @(negedge clock) begin
      logic [7:0] exp;
      if (outValid[0] === 1'b1 && outReady[0] === 1'b1) begin
         checkOutput("sb0_has_entry", (sb0.size() > 0), 1);
         if (sb0.size() > 0) begin
            exp = sb0.pop_front();
            checkOutput("cipher_r2", cipherOut[0], exp);
         end
      end
      if (outValid[1] === 1'b1 && outReady[1] === 1'b1) begin
         checkOutput("sb1_has_entry", (sb1.size() > 0), 1);
         if (sb1.size() > 0) begin
            exp = sb1.pop_front();
            checkOutput("cipher_r4", cipherOut[1], exp);
         end
      end
   end

   // Key load with edge counting; optionally offers a block in the same cycle
   task automatic loadKey(input int d, input logic [9:0] key, input bit withValid);
      int n;
      stepCycle();
      keyLoad[d] = 1'b1;
      keyIn[d]   = key;
      if (withValid) begin
         inValid[d] = 1'b1;
         qIn[d]     = 8'h3C;
      end
      @(negedge clock);
      if (withValid) checkOutput("keyload_wins_inready", inReady[d], 0);
      stepCycle();
      keyLoad[d] = 1'b0;
      inValid[d] = 1'b0;
      keyIn[d]   = ~key;
      n = 0;
      while (n < 40) begin
         @(negedge clock);
         if (n == 0) checkOutput("keygen_state", debugOut[d][3:2], 2'b01);
         if (keyReady[d] === 1'b1) break;
         stepCycle();
         n++;
      end
      checkOutput("keyready_latency", n, RND[d]);
   endtask

   // Offers one block, checks latency and optional backpressure, then drains it
   task automatic applyStimulus(input int d, input logic [7:0] q, input logic dec,
                                input logic [7:0] expected, input int hold);
      int         n;
      logic [7:0] held;
      stepCycle();
      inValid[d] = 1'b1;
      qIn[d]     = q;
      decIn[d]   = dec;
      n = 0;
      while (n < 40) begin
         @(negedge clock);
         if (inReady[d] === 1'b1) break;
         stepCycle();
         n++;
      end
      checkOutput("accept_timeout", (n < 40), 1);
      if (d == 0) sb0.push_back(expected);
      else        sb1.push_back(expected);
      stepCycle();
      inValid[d] = 1'b0;
      qIn[d]     = ~q;
      decIn[d]   = ~dec;
      n = 0;
      while (n < 40) begin
         @(negedge clock);
         if (outValid[d] === 1'b1) break;
         stepCycle();
         n++;
      end
      checkOutput("outvalid_latency", n, RND[d]);
      held = cipherOut[d];
      for (int h = 0; h < hold; h++) begin
         stepCycle();
         qIn[d] = q ^ 8'(h + 1);
         @(negedge clock);
         checkOutput("hold_cipher", cipherOut[d], held);
         checkOutput("hold_outvalid", outValid[d], 1);
         checkOutput("hold_inready", inReady[d], 0);
      end
      stepCycle();
      outReady[d] = 1'b1;
      @(negedge clock);
      stepCycle();
      outReady[d] = 1'b0;
      @(negedge clock);
      checkOutput("outvalid_fall", outValid[d], 0);
      checkOutput("inready_return", inReady[d], 1);
   endtask

   // Main sequence
   initial begin
      logic [9:0] rkey;
      logic [7:0] ct;
      int         n;
      for (int d = 0; d < 2; d++) begin
         keyIn[d] = '0; keyLoad[d] = 1'b0; inValid[d] = 1'b0;
         qIn[d] = '0; decIn[d] = 1'b0; outReady[d] = 1'b0;
      end
      reset = 1'b1;
      stepCycle();
      stepCycle();
      reset = 1'b0;

      $display("[TB] reset and idle");
      for (int c = 0; c < 3; c++) begin
         inValid[0] = (c == 1);
         qIn[0]     = 8'hA5;
         @(negedge clock);
         checkOutput("rst_keyready", keyReady[0], 0);
         checkOutput("rst_inready", inReady[0], 0);
         checkOutput("rst_outvalid", outValid[0], 0);
         checkOutput("rst_cipher", cipherOut[0], 8'h00);
         checkOutput("rst_debug", debugOut[0], 4'h0);
         checkOutput("rst_keyready_r4", keyReady[1], 0);
         stepCycle();
      end
      inValid[0] = 1'b0;
      @(negedge clock);
      checkOutput("idle_not_accepted", debugOut[0], 4'h0);

      $display("[TB] ROUNDS=2 known vectors");
      loadKey(0, 10'b1010101010, 0);
      applyStimulus(0, 8'hF0, 1'b0, 8'h59, 5);
      applyStimulus(0, 8'hAA, 1'b0, 8'h6B, 0);
      loadKey(0, 10'b1011111101, 1);
      applyStimulus(0, 8'hFE, 1'b0, 8'hE6, 1);
      applyStimulus(0, 8'h7F, 1'b1, 8'h00, 0);
      loadKey(0, 10'b1111100000, 0);
      applyStimulus(0, 8'h99, 1'b0, 8'h3C, 0);
      applyStimulus(0, 8'hAA, 1'b1, 8'h7A, 2);

      $display("[TB] ROUNDS=4 round trips");
      rkey = 10'($urandom_range(0, 1023));
      loadKey(1, rkey, 0);
      for (int x = 0; x < 256; x++) begin
         ct = modelCrypt(4, rkey, 8'(x), 1'b0);
         applyStimulus(1, 8'(x), 1'b0, ct, 0);
         applyStimulus(1, ct, 1'b1, 8'(x), 0);
      end

      $display("[TB] reset during RUN");
      stepCycle();
      inValid[1] = 1'b1;
      qIn[1]     = 8'h5A;
      decIn[1]   = 1'b0;
      n = 0;
      while (n < 40) begin
         @(negedge clock);
         if (inReady[1] === 1'b1) break;
         stepCycle();
         n++;
      end
      stepCycle();
      inValid[1] = 1'b0;
      stepCycle();
      @(negedge clock);
      checkOutput("midrun_state", debugOut[1][3:2], 2'b10);
      stepCycle();
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_run_outvalid", outValid[1], 0);
      checkOutput("rst_run_keyready", keyReady[1], 0);
      checkOutput("rst_run_debug", debugOut[1], 4'h0);
      checkOutput("rst_run_cipher", cipherOut[1], 8'h00);
      for (int c = 0; c < 8; c++) begin
         outReady[1] = 1'b1;
         stepCycle();
         @(negedge clock);
         checkOutput("no_result_after_rst", outValid[1], 0);
      end
      outReady[1] = 1'b0;

      checkOutput("sb0_drained", sb0.size(), 0);
      checkOutput("sb1_drained", sb1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sdes_round_engine.md
# sdes_round_engine

Iterative, parametrised successor to the combinational S-DES `crypt` datapath. It expands a 10-bit key into ROUNDS 8-bit subkeys internally, then runs one Feistel round per clock. Encrypt or decrypt is selected per block, and blocks move through valid/ready handshakes. It sits between the block source (UART/switch front end) and the display/sink logic. With ROUNDS=2 it is bit-exact with standard S-DES.

## Interface
- ROUNDS, 2, Feistel round count; even, 2..16
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- key_in  in  10  master key, bit 9 = S-DES bit 1
- key_load  in  1  one-cycle strobe; starts key expansion
- key_ready  out  1  subkeys valid, engine usable
- in_valid  in  1  block offered
- in_ready  out  1  engine can accept block
- q_in  in  8  plaintext or ciphertext, bit 7 = S-DES bit 1
- decrypt  in  1  captured with block; 1 = use subkeys in reverse order
- out_valid  out  1  cipher holds result
- out_ready  in  1  sink accepts result
- cipher  out  8  result block
- debug  out  4  {state[1:0], round_cnt[1:0]}

## Operation
- Permutations use S-DES bit numbering, where bit 1 is the MSB:
  - P10 3 5 2 7 4 10 1 9 8 6
  - P8 6 3 7 4 8 5 10 9
  - IP 2 6 3 1 4 8 5 7
  - IP⁻¹ 4 1 3 5 7 2 8 6
  - E/P 4 1 2 3 2 3 4 1
  - P4 2 4 3 1
- S-boxes are indexed with row = bits 1,4 and column = bits 2,3:
  - S0 rows: 1 0 3 2 / 3 2 1 0 / 0 2 1 3 / 3 1 3 2
  - S1 rows: 0 1 2 3 / 2 0 1 3 / 3 0 1 0 / 2 1 0 3
- Key schedule:
  - Apply P10, then split into 5-bit halves.
  - Subkey K_r (r = 1..ROUNDS) = P8 of both halves rotated left by (1 + 2(r−1)) mod 5 total.
  - ROUNDS=2 gives the standard K1 and K2.
- Round function:
  - Round r maps (L,R) to (L xor F(R,K), R).
  - F(R,K) = P4(S0‖S1(E/P(R) xor K)).
  - Halves are swapped after every round except the last.
- Key order:
  - Encrypt uses K1..K_ROUNDS.
  - Decrypt uses K_ROUNDS..K1.
- States:
  - IDLE (00): in_ready = key_ready.
  - KEYGEN (01): one subkey written per cycle.
  - RUN (10): one round per cycle.
  - DONE (11): out_valid = 1.
- Transitions:
  - IDLE→KEYGEN on key_load. Key_load wins over a simultaneous in_valid: in_ready is forced low that cycle and the block is not taken.
  - KEYGEN→IDLE after ROUNDS cycles; key_ready is set on that edge.
  - key_load during KEYGEN restarts expansion with the new key_in, and key_ready stays 0.
  - IDLE→RUN on in_valid && in_ready. On that edge the engine captures IP(q_in) and decrypt, and clears round_cnt.
  - RUN→DONE after the ROUNDS-th round.
  - DONE→IDLE on out_ready.
- key_load during RUN or DONE is ignored.
- q_in and decrypt are sampled only on the accept edge. Later changes to them have no effect.
- round_cnt counts 0..ROUNDS−1 and is 4 bits wide internally. debug shows only its low 2 bits.

## Timing
- Reset values:
  - State IDLE.
  - key_ready = 0, in_ready = 0, out_valid = 0.
  - cipher = 8'h00, debug = 4'b0000.
  - Key register and subkey file cleared.
- Key expansion:
  - key_load is sampled at edge k.
  - key_ready rises after edge k+ROUNDS.
- Block latency:
  - The accept edge is t0.
  - Rounds execute on edges t1..tROUNDS.
  - cipher is loaded with IP⁻¹ of the final state at tROUNDS, and out_valid rises at that edge. For ROUNDS=2, out_valid is high 2 cycles after accept.
- Output hold:
  - cipher is stable while out_valid && !out_ready.
  - out_valid falls on the edge where out_ready is sampled high.
  - in_ready returns the following cycle.
- Throughput: one block per ROUNDS+2 cycles at best. There is no overlap between blocks.
- Reset mid-operation (any state): the next edge returns everything to reset values. Subkeys are lost, so a new key_load is required.

## Test plan
- Reset then idle for 3 cycles. Required: key_ready = in_ready = out_valid = 0, cipher = 00, debug = 0. An in_valid pulse during this time is not accepted.
- ROUNDS=2, key 1010101010:
  - Encrypt F0 → 59.
  - Encrypt AA → 6B.
  - key_ready must rise exactly 2 edges after key_load.
  - out_valid must rise exactly 2 edges after the accept edge.
- ROUNDS=2, key 1011111101: encrypt FE → E6, decrypt 7F → 00.
- ROUNDS=2, key 1111100000: encrypt 99 → 3C, decrypt AA → 7A.
- Backpressure: hold out_ready low for 5 cycles with out_valid high. Required: cipher is constant and in_ready = 0. Change q_in during RUN; cipher must be unaffected. Also assert key_load and in_valid in the same cycle; key_load must win.
- ROUNDS=4, random key:
  - Decrypt(encrypt(x)) == x for all 256 values of x.
  - Assert reset during RUN. Required: out_valid = 0 and key_ready = 0 after the next edge, and no result is emitted.
